io_in_capture: RTL and testbench

IO_IN_CAPTURE -- requirements
Module: io_in_capture

---
 rtl/io_capture_pkg.sv | 32 +++
 rtl/io_edge_counter.sv | 61 ++++++
 rtl/io_in_capture.sv | 177 +++++++++++++++++
 tb/tb_io_in_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/io_capture_pkg.sv
// Shared constants for the io_in_capture block: register word offsets,
// ID value, CTRL field positions and the bus responder state encoding.
package io_capture_pkg;

  localparam int IO_W = 38;

  localparam logic [31:0] ID_VALUE = 32'h10C0_0001;

  // Word offsets (byte address bits [4:2]); offset 7 (0x1C) is unmapped.
  localparam logic [2:0] REG_ID     = 3'd0;
  localparam logic [2:0] REG_IN_LO  = 3'd1;
  localparam logic [2:0] REG_IN_HI  = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;
  localparam logic [2:0] REG_CMP    = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;

  // CTRL fields
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_PIN_LSB = 1;
  localparam int CTRL_PIN_W   = 6;
  localparam int CTRL_CLR_BIT = 7;

  // Highest selectable pad index; larger pin values count nothing.
  localparam logic [5:0] PIN_MAX = 6'd37;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/io_edge_counter.sv
// Rising-edge counter on one selectable synchronized pad, with a sticky
// compare-match flag.
import io_capture_pkg::*;

module io_edge_counter (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IO_W-1:0] io_sync,
  input  logic            en,
  input  logic [5:0]      pin,
  input  logic            clr,
  input  logic [31:0]     cmp,
  input  logic            match_clr,
  output logic [31:0]     count_o,
  output logic            match_o
);

  logic        prev_q, prev_d;
  logic [5:0]  pin_q, pin_d;
  logic [31:0] count_q, count_d;
  logic        match_q, match_d;
  logic        pin_valid, sel_bit, pin_changed, rise, match_set;

  // Pin mux, edge detect (suppressed right after a pin change), count and match.
  always_comb begin
    pin_valid   = (pin <= PIN_MAX);
    sel_bit     = pin_valid ? io_sync[pin] : 1'b0;
    pin_changed = (pin != pin_q);
    rise        = en & pin_valid & ~pin_changed & sel_bit & ~prev_q;
    prev_d      = sel_bit;
    pin_d       = pin;
    count_d     = count_q;
    if (clr) begin
      count_d = 32'd0;
    end else if (rise) begin
      count_d = count_q + 32'd1;
    end
    // Match fires only on a change of COUNT into the compare value.
    match_set = (count_d != count_q) && (count_d == cmp);
    match_d   = match_set | (match_q & ~match_clr);
  end

  // State registers for the counter path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      pin_q   <= 6'd0;
      count_q <= 32'd0;
      match_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pin_q   <= pin_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  assign count_o = count_q;
  assign match_o = match_q;

endmodule

// File: rtl/io_in_capture.sv
// Wishbone classic register block that samples 38 pad inputs and counts
// rising edges on one selected pad.
// Optional build macro IO_CAPTURE_IRQ_EN drives user_irq[0] from STATUS.match.
import io_capture_pkg::*;

module io_in_capture (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_oeb,
  output logic [2:0]      user_irq
);

  // Handshake: a request (cyc & stb) seen in IDLE is latched and answered
  // with ack for exactly one cycle; the responder then returns to IDLE, so
  // the master must deassert stb once it sees ack.

  logic [IO_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  wb_state_e       state_q, state_d;
  logic [2:0]      req_adr_q, req_adr_d;
  logic            req_we_q, req_we_d;
  logic [31:0]     req_dat_q, req_dat_d;
  logic [3:0]      req_sel_q, req_sel_d;
  logic [31:0]     dat_q, dat_d;
  logic            ctrl_en_q, ctrl_en_d;
  logic [5:0]      ctrl_pin_q, ctrl_pin_d;
  logic [31:0]     cmp_q, cmp_d;
  logic [31:0]     rd_data;
  logic            wr_en, clr_pulse, match_clr;
  logic [31:0]     count;
  logic            match;
  logic            unused_adr;

  assign unused_adr = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0]};

  // Two-flop synchronizer on all pads.
  always_comb begin
    sync1_d = io_in;
    sync2_d = sync1_q;
  end

  // Read mux over the synchronized view.
  always_comb begin
    rd_data = 32'd0;
    case (wbs_adr_i[4:2])
      REG_ID:     rd_data = ID_VALUE;
      REG_IN_LO:  rd_data = sync2_q[31:0];
      REG_IN_HI:  rd_data = {26'd0, sync2_q[37:32]};
      REG_CTRL:   rd_data = {24'd0, 1'b0, ctrl_pin_q, ctrl_en_q};
      REG_COUNT:  rd_data = count;
      REG_CMP:    rd_data = cmp_q;
      REG_STATUS: rd_data = {31'd0, match};
      default:    rd_data = 32'd0;
    endcase
  end

  // Responder FSM: accept in IDLE, ack one cycle, return to IDLE.
  always_comb begin
    state_d   = state_q;
    req_adr_d = req_adr_q;
    req_we_d  = req_we_q;
    req_dat_d = req_dat_q;
    req_sel_d = req_sel_q;
    dat_d     = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d   = ST_ACK;
          req_adr_d = wbs_adr_i[4:2];
          req_we_d  = wbs_we_i;
          req_dat_d = wbs_dat_i;
          req_sel_d = wbs_sel_i;
          dat_d     = rd_data;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register writes take effect in the ack cycle from the latched request.
  always_comb begin
    wr_en      = (state_q == ST_ACK) && req_we_q;
    ctrl_en_d  = ctrl_en_q;
    ctrl_pin_d = ctrl_pin_q;
    cmp_d      = cmp_q;
    clr_pulse  = 1'b0;
    match_clr  = 1'b0;
    if (wr_en) begin
      if (req_adr_q == REG_CTRL && req_sel_q[0]) begin
        ctrl_en_d  = req_dat_q[CTRL_EN_BIT];
        ctrl_pin_d = req_dat_q[CTRL_PIN_LSB +: CTRL_PIN_W];
        clr_pulse  = req_dat_q[CTRL_CLR_BIT];
      end
      if (req_adr_q == REG_CMP) begin
        for (int b = 0; b < 4; b++) begin
          if (req_sel_q[b]) cmp_d[8*b +: 8] = req_dat_q[8*b +: 8];
        end
      end
      if (req_adr_q == REG_STATUS && req_sel_q[0]) begin
        match_clr = req_dat_q[0];
      end
    end
  end

  // Bus-side and configuration registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= ST_IDLE;
      req_adr_q  <= 3'd0;
      req_we_q   <= 1'b0;
      req_dat_q  <= 32'd0;
      req_sel_q  <= 4'd0;
      dat_q      <= 32'd0;
      ctrl_en_q  <= 1'b0;
      ctrl_pin_q <= 6'd0;
      cmp_q      <= 32'd0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      req_adr_q  <= req_adr_d;
      req_we_q   <= req_we_d;
      req_dat_q  <= req_dat_d;
      req_sel_q  <= req_sel_d;
      dat_q      <= dat_d;
      ctrl_en_q  <= ctrl_en_d;
      ctrl_pin_q <= ctrl_pin_d;
      cmp_q      <= cmp_d;
    end
  end

  io_edge_counter u_edge (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n),
    .io_sync   (sync2_q),
    .en        (ctrl_en_q),
    .pin       (ctrl_pin_q),
    .clr       (clr_pulse),
    .cmp       (cmp_q),
    .match_clr (match_clr),
    .count_o   (count),
    .match_o   (match)
  );

  assign wbs_ack_o = (state_q == ST_ACK);
  assign wbs_dat_o = wbs_ack_o ? dat_q : 32'd0;
  assign io_oeb    = '1;

`ifdef IO_CAPTURE_IRQ_EN
  logic irq_q, irq_d;

  // Registered copy of the match flag as the interrupt line.
  always_comb irq_d = match;

  // Interrupt register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end

  assign user_irq = {2'b00, irq_q};
`else
  assign user_irq = 3'b000;
`endif

endmodule

// File: tb/tb_io_in_capture.sv
// Directed bench for io_in_capture.
module tb_io_in_capture;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_in;
  logic [37:0] io_oeb;
  logic [2:0]  user_irq;

  int vecs = 0;
  int miscompares = 0;
  logic irq_exp;

  io_in_capture dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_sel_i (sel),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_oeb    (io_oeb),
    .user_irq  (user_irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus access; lat = cycles from request to ack (0 = no ack in budget).
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0; rd = 32'd0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        rd  = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    int lat;
    xfer(a, 1'b0, 32'd0, 4'hF, rd, lat);
    chk({tag, "_lat"}, lat, 1);
    chk(tag, rd, exp);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic [31:0] rd;
    int lat;
    xfer(a, 1'b1, d, s, rd, lat);
    chk({tag, "_lat"}, lat, 1);
  endtask

  task automatic pulse(input int b);
    @(posedge clk); #1 io_in[b] = 1'b1;
    repeat (3) @(posedge clk);
    #1 io_in[b] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
`ifdef IO_CAPTURE_IRQ_EN
    irq_exp = 1'b1;
`else
    irq_exp = 1'b0;
`endif
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 32'd0; wdat = 32'd0; sel = 4'd0; io_in = 38'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_irq", user_irq, 0);
    chk("oeb", io_oeb, 64'h3F_FFFF_FFFF);
    @(negedge clk) rst_n = 1'b1;

    // ID read, one-cycle ack, then ack low again
    wb_rd(32'h00, 32'h10C0_0001, "id");
    @(posedge clk); #1;
    chk("ack_drop", ack, 0);
    chk("dat_idle", rdat, 0);

    // Pad view through the synchronizer
    io_in = 38'h2A_1234_5678;
    repeat (3) @(posedge clk);
    wb_rd(32'h04, 32'h1234_5678, "in_lo");
    wb_rd(32'h08, 32'h0000_002A, "in_hi");
    io_in = 38'd0;
    repeat (3) @(posedge clk);
    wb_rd(32'h10, 32'd0, "count_disabled");

    // Count on pin 5, ignore pin 6
    wb_wr(32'h0C, 32'h0000_000B, 4'hF, "ctrl_wr");
    wb_rd(32'h0C, 32'h0000_000B, "ctrl_rd");
    repeat (3) pulse(5);
    repeat (3) pulse(6);
    repeat (4) @(posedge clk);
    wb_rd(32'h10, 32'd3, "count3");
    wb_rd(32'h18, 32'd0, "status_cmp0");

    // Wrap with CMP=5
    wb_wr(32'h14, 32'd5, 4'hF, "cmp5_wr");
    @(negedge clk) force dut.u_edge.count_q = 32'hFFFF_FFFE;
    @(negedge clk) release dut.u_edge.count_q;
    pulse(5);
    wb_rd(32'h10, 32'hFFFF_FFFF, "count_max");
    pulse(5);
    wb_rd(32'h10, 32'd0, "count_wrap");
    wb_rd(32'h18, 32'd0, "status_wrap");

    // Match on CMP=2
    wb_wr(32'h14, 32'd2, 4'hF, "cmp2_wr");
    repeat (2) pulse(5);
    wb_rd(32'h10, 32'd2, "count2");
    wb_rd(32'h18, 32'd1, "status_match");
    chk("irq_match", user_irq, {2'b00, irq_exp});
    wb_wr(32'h18, 32'd1, 4'hF, "status_w1c");
    wb_rd(32'h18, 32'd0, "status_cleared");
    chk("irq_cleared", user_irq, 0);

    // clr coincident with a detected edge: edge reaches the counter in the ack cycle
    @(posedge clk); #1 io_in[5] = 1'b1;
    wb_wr(32'h0C, 32'h0000_008B, 4'hF, "ctrl_clr");
    repeat (3) @(posedge clk);
    wb_rd(32'h10, 32'd0, "count_clr_edge");
    wb_rd(32'h0C, 32'h0000_000B, "ctrl_clr_reads0");
    io_in[5] = 1'b0;

    // Byte enables
    wb_wr(32'h0C, 32'hFFFF_FF03, 4'b0001, "ctrl_sel");
    wb_rd(32'h0C, 32'h0000_0003, "ctrl_sel_rd");
    wb_rd(32'h14, 32'd2, "cmp_intact");
    wb_wr(32'h14, 32'hAABB_CCDD, 4'b0010, "cmp_sel");
    wb_rd(32'h14, 32'h0000_CC02, "cmp_sel_rd");
    wb_wr(32'h00, 32'hDEAD_BEEF, 4'hF, "id_wr");
    wb_rd(32'h00, 32'h10C0_0001, "id_ro");
    wb_wr(32'h1C, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
    wb_rd(32'h1C, 32'd0, "unmapped_rd");

    // Reset in the ack cycle
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00; sel = 4'hF;
    @(posedge clk); #1;
    chk("ack_before_rst", ack, 1);
    rst_n = 1'b0;
    #1;
    chk("ack_in_rst", ack, 0);
    chk("dat_in_rst", rdat, 0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #2;
    chk("no_late_ack", ack, 0);
    wb_rd(32'h0C, 32'd0, "ctrl_after_rst");
    wb_rd(32'h14, 32'd0, "cmp_after_rst");
    wb_rd(32'h10, 32'd0, "count_after_rst");
    wb_rd(32'h18, 32'd0, "status_after_rst");

    // Pin beyond the pad range counts nothing
    wb_wr(32'h0C, 32'h0000_0051, 4'hF, "ctrl_pin40");
    repeat (3) begin
      @(posedge clk); #1 io_in = '1;
      repeat (3) @(posedge clk);
      #1 io_in = '0;
      repeat (3) @(posedge clk);
    end
    wb_rd(32'h10, 32'd0, "count_pin40");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
